// File: rtl/wb_uart_tx_sched.sv
// Wishbone master that shares one wb_uart transmitter among NREQ byte requesters.
// Round-robin grant, poll UCR until tx_busy clears, then write the byte to DATA.
module wb_uart_tx_sched #(
    parameter int unsigned NREQ        = 4,
    parameter logic [31:0] BASE_ADR    = 32'h0,
    parameter int unsigned POLL_GAP    = 2,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [31:0]       wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic              err,
    input  logic              err_clr,
    output logic [15:0]       tx_count
);

    localparam int unsigned PtrW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  GapInit = 8'(POLL_GAP - 1);
    localparam logic [7:0]  TmoLast = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StPoll, StWrite, StGap} state_e;

    state_e          state_q, state_d;
    state_e          after_q, after_d;
    logic [PtrW-1:0] rr_q, rr_d;
    logic [7:0]      byte_q, byte_d;
    logic [2:0]      grant_q, grant_d;
    logic            err_q, err_d;
    logic [15:0]     tx_cnt_q, tx_cnt_d;
    logic [7:0]      tmo_q, tmo_d;
    logic [7:0]      gap_q, gap_d;

    logic            sel_found;
    logic [PtrW-1:0] sel_idx;
    logic [PtrW-1:0] cand_idx;
    logic [PtrW-1:0] rr_next;

    // Only tx_busy is meaningful in the status word.
    logic unused_dat;
    assign unused_dat = ^{wb_dat_i[31:5], wb_dat_i[3:0]};

    // First valid requester at or above the pointer, wrapping at NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand_idx = PtrW'((32'(rr_q) + 32'(k)) % NREQ);
            if (!sel_found && req_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
        rr_next = (sel_idx == PtrW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        after_d   = after_q;
        rr_d      = rr_q;
        byte_d    = byte_q;
        grant_d   = grant_q;
        err_d     = err_q;
        tx_cnt_d  = tx_cnt_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        req_ready = '0;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_adr_o  = '0;
        wb_sel_o  = '0;
        wb_dat_o  = '0;

        if (err_clr) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (sel_found && !reset) begin
                    req_ready[sel_idx] = 1'b1;
                    byte_d             = req_data[{sel_idx, 3'b000} +: 8];
                    grant_d            = 3'(sel_idx);
                    rr_d               = rr_next;
                    tmo_d              = '0;
                    state_d            = StPoll;
                end
            end
            StPoll: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_adr_o = BASE_ADR;
                wb_sel_o = 4'hF;
                if (wb_ack_i) begin
                    after_d = wb_dat_i[4] ? StPoll : StWrite;
                    gap_d   = GapInit;
                    state_d = StGap;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    after_d = StIdle;
                    gap_d   = GapInit;
                    state_d = StGap;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StWrite: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = BASE_ADR + 32'd4;
                wb_sel_o = 4'b0001;
                wb_dat_o = {24'b0, byte_q};
                if (wb_ack_i) begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                    after_d  = StIdle;
                    gap_d    = GapInit;
                    state_d  = StGap;
                end else if (tmo_q == TmoLast) begin
                    // Byte is dropped; the requester already had its handshake.
                    err_d   = 1'b1;
                    after_d = StIdle;
                    gap_d   = GapInit;
                    state_d = StGap;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    tmo_d   = '0;
                    state_d = after_q;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            after_q  <= StIdle;
            rr_q     <= '0;
            byte_q   <= '0;
            grant_q  <= '0;
            err_q    <= 1'b0;
            tx_cnt_q <= '0;
            tmo_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            after_q  <= after_d;
            rr_q     <= rr_d;
            byte_q   <= byte_d;
            grant_q  <= grant_d;
            err_q    <= err_d;
            tx_cnt_q <= tx_cnt_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign grant_id = grant_q;
    assign err      = err_q;
    assign tx_count = tx_cnt_q;

endmodule

// File: tb/tb_wb_uart_tx_sched.sv
// Directed bench for wb_uart_tx_sched: four requesters, a registered-ack UART slave
// model with programmable busy polls and a write-ack stall switch.
module tb_wb_uart_tx_sched;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned POLL_GAP = 2;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ready;
    logic              wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0]       wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]        wb_sel_o;
    logic              wb_ack_i;
    logic              busy;
    logic [2:0]        grant_id;
    logic              err;
    logic              err_clr   = 1'b0;
    logic [15:0]       tx_count;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_uart_tx_sched #(
        .NREQ       (NREQ),
        .BASE_ADR   (32'h0),
        .POLL_GAP   (POLL_GAP),
        .ACK_TIMEOUT(255)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .busy     (busy),
        .grant_id (grant_id),
        .err      (err),
        .err_clr  (err_clr),
        .tx_count (tx_count)
    );

    // UART slave model: ack one cycle after stb, tx_busy reported while rd_cnt < busy_until.
    logic        ack_q       = 1'b0;
    logic        nack_wr     = 1'b0;
    int          cyc_n       = 0;
    int          rd_cnt      = 0;
    int          wr_cnt      = 0;
    int          busy_until  = 0;
    int          stall_cnt   = 0;
    int          g_cnt       = 0;
    logic [31:0] rd_adr_last = '0;
    int          rd_cyc [64];
    logic [31:0] wr_adr [64];
    logic [31:0] wr_dat [64];
    logic [3:0]  wr_sel [64];
    int          grants [64];

    assign wb_ack_i = ack_q;
    assign wb_dat_i = (rd_cnt < busy_until) ? 32'h0000_0010 : 32'h0;

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < int'(NREQ); i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        ack_q <= wb_cyc_o && wb_stb_o && !ack_q && !(wb_we_o && nack_wr);
        if (ack_q && wb_stb_o && !wb_we_o) begin
            rd_cyc[rd_cnt % 64] <= cyc_n;
            rd_adr_last         <= wb_adr_o;
            rd_cnt              <= rd_cnt + 1;
        end
        if (ack_q && wb_stb_o && wb_we_o) begin
            wr_adr[wr_cnt % 64] <= wb_adr_o;
            wr_dat[wr_cnt % 64] <= wb_dat_o;
            wr_sel[wr_cnt % 64] <= wb_sel_o;
            wr_cnt              <= wr_cnt + 1;
        end
        if (wb_stb_o && wb_we_o && !ack_q) stall_cnt <= stall_cnt + 1;
        if (|(req_valid & req_ready)) begin
            grants[g_cnt % 64] <= oh_idx(req_valid & req_ready);
            g_cnt              <= g_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int idx, input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        req_data[8*idx +: 8] = b;
        req_valid[idx]       = 1'b1;
        #1;
        while (!req_ready[idx] && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("send handshake", 32'(req_ready[idx]), 32'd1);
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_wr_stb();
        int guard;
        guard = 0;
        while (!(wb_stb_o && wb_we_o) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("write strobe seen", 32'(wb_stb_o && wb_we_o), 32'd1);
    endtask

    initial begin
        int          n, g0, w0, r0, s0;
        logic [15:0] tc0;

        // Reset state, with requests pending to show no handshake leaks out.
        req_valid = 4'hF;
        #2;
        check("rst cyc", 32'(wb_cyc_o), 32'd0);
        check("rst stb", 32'(wb_stb_o), 32'd0);
        check("rst we", 32'(wb_we_o), 32'd0);
        check("rst adr", wb_adr_o, 32'd0);
        check("rst sel", 32'(wb_sel_o), 32'd0);
        check("rst dat", wb_dat_o, 32'd0);
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst grant", 32'(grant_id), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst count", 32'(tx_count), 32'd0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;

        // Single byte: latency and bus transactions.
        @(negedge clk);
        req_data[7:0] = 8'h41;
        req_valid     = 4'b0001;
        r0 = rd_cnt;
        w0 = wr_cnt;
        #1;
        check("sb ready c0", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("sb poll cyc/stb/we", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'b110);
        check("sb poll adr", wb_adr_o, 32'h0);
        check("sb poll sel", 32'(wb_sel_o), 32'hF);
        check("sb ready c1", 32'(req_ready), 32'h0);
        n = 1;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 3 + int'(POLL_GAP)) check("sb write stb", 32'({wb_stb_o, wb_we_o}), 32'b11);
        end
        check("sb idle cycle", 32'(n), 32'd9);
        check("sb reads", 32'(rd_cnt - r0), 32'd1);
        check("sb read adr", rd_adr_last, 32'h0);
        check("sb writes", 32'(wr_cnt - w0), 32'd1);
        check("sb write adr", wr_adr[w0 % 64], 32'h4);
        check("sb write dat", wr_dat[w0 % 64], 32'h0000_0041);
        check("sb write sel", 32'(wr_sel[w0 % 64]), 32'h1);
        check("sb count", 32'(tx_count), 32'd1);
        check("sb grant", 32'(grant_id), 32'd0);

        // Contention from a fresh pointer: order 0,1,2,3,0.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        g0 = g_cnt;
        w0 = wr_cnt;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'hF;
        n = 0;
        while ((g_cnt - g0) < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_valid = '0;
        wait_idle(n);
        check("ct grants", 32'(g_cnt - g0), 32'd5);
        check("ct writes", 32'(wr_cnt - w0), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("ct grant order", 32'(grants[(g0 + k) % 64]), 32'(k % 4));
            check("ct write order", wr_dat[(w0 + k) % 64], 32'h0000_00A0 + 32'(k % 4));
        end

        // UART reports busy for three polls.
        r0 = rd_cnt;
        w0 = wr_cnt;
        busy_until = rd_cnt + 3;
        send(1, 8'h77);
        wait_idle(n);
        check("bp reads", 32'(rd_cnt - r0), 32'd4);
        check("bp writes", 32'(wr_cnt - w0), 32'd1);
        check("bp write dat", wr_dat[w0 % 64], 32'h0000_0077);
        for (int k = 0; k < 3; k++) begin
            check("bp read spacing", 32'(rd_cyc[(r0 + k + 1) % 64] - rd_cyc[(r0 + k) % 64]),
                  32'(POLL_GAP + 2));
        end

        // Write never acked: timeout after 255 stall cycles.
        nack_wr = 1'b1;
        tc0 = tx_count;
        w0  = wr_cnt;
        s0  = stall_cnt;
        send(2, 8'h55);
        wait_idle(n);
        check("to stall cycles", 32'(stall_cnt - s0), 32'd255);
        check("to err", 32'(err), 32'd1);
        check("to count held", 32'(tx_count), 32'(tc0));
        check("to no write", 32'(wr_cnt - w0), 32'd0);
        nack_wr = 1'b0;
        send(3, 8'h66);
        wait_idle(n);
        check("to next count", 32'(tx_count), 32'(tc0) + 32'd1);
        check("to next dat", wr_dat[w0 % 64], 32'h0000_0066);
        check("to err sticky", 32'(err), 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to err cleared", 32'(err), 32'd0);

        // err_clr coinciding with a timeout leaves err set.
        nack_wr = 1'b1;
        send(0, 8'h12);
        wait_wr_stb();
        repeat (254) @(negedge clk);
        check("tc last stall stb", 32'(wb_stb_o), 32'd1);
        check("tc err before", 32'(err), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("tc err wins", 32'(err), 32'd1);
        check("tc stb dropped", 32'(wb_stb_o), 32'd0);
        wait_idle(n);

        // Asynchronous reset during a stalled write.
        send(2, 8'h99);
        wait_wr_stb();
        reset = 1'b1;
        #1;
        check("rw cyc/stb/we", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
        check("rw count", 32'(tx_count), 32'd0);
        check("rw busy", 32'(busy), 32'd0);
        check("rw err", 32'(err), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        nack_wr = 1'b0;
        w0 = wr_cnt;
        @(negedge clk);
        req_data  = {8'hC3, 8'h00, 8'h00, 8'hC0};
        req_valid = 4'b1001;
        #1;
        check("rw first grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle(n);
        check("rw write dat", wr_dat[w0 % 64], 32'h0000_00C0);
        check("rw count after", 32'(tx_count), 32'd1);

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.tx_cnt_q = 16'hFFFF;
        #1 release dut.tx_cnt_q;
        send(1, 8'h5A);
        wait_idle(n);
        check("wrap to zero", 32'(tx_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
